// File: rtl/scoreboard_issue_pkg.sv
// Shared types and constants for the scoreboard issue stage.
// FU encodings, register geometry and the holding-register bundle.
package scoreboard_issue_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int FU_W       = 2;
   localparam int BUSY_W     = 4;

   localparam logic [FU_W-1:0] FU_ALU = 2'd0;
   localparam logic [FU_W-1:0] FU_MUL = 2'd1;
   localparam logic [FU_W-1:0] FU_DIV = 2'd2;
   localparam logic [FU_W-1:0] FU_LSU = 2'd3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic                  uses_rt;
      logic [REG_ADDR_W-1:0] rd;
      logic                  writes_rd;
      logic [FU_W-1:0]       fu;
   } instr_t;

   // A unit occupied for N cycles reloads to N-1; zero means free next cycle.
   function automatic logic [BUSY_W-1:0] busy_load(int unsigned cycles);
      return (cycles > 0) ? BUSY_W'(cycles - 1) : '0;
   endfunction

endpackage

// File: rtl/scoreboard_issue_if.sv
// Decode/execute/scoreboard signal bundle around the issue stage.
// master drives decode-side inputs; slave is the issue stage.
interface scoreboard_issue_if #(
   parameter int CNT_W = 16
);
   import scoreboard_issue_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] in_rs;
   logic [REG_ADDR_W-1:0] in_rt;
   logic                  in_uses_rt;
   logic [REG_ADDR_W-1:0] in_rd;
   logic                  in_writes_rd;
   logic [FU_W-1:0]       in_fu;
   logic [NUM_REGS-1:0]   pnd_sgn;
   logic                  out_valid;
   logic                  out_ready;
   logic [REG_ADDR_W-1:0] out_rs;
   logic [REG_ADDR_W-1:0] out_rt;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [FU_W-1:0]       out_fu;
   logic                  out_writes_rd;
   logic [REG_ADDR_W-1:0] sb_reg_addr;
   logic [FU_W-1:0]       sb_func_uni;
   logic                  sb_wre;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output in_valid, in_rs, in_rt, in_uses_rt,
      output in_rd, in_writes_rd, in_fu,
      output pnd_sgn, out_ready,
      input  in_ready, out_valid, out_rs, out_rt,
      input  out_rd, out_fu, out_writes_rd,
      input  sb_reg_addr, sb_func_uni, sb_wre, stall_cnt
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_uses_rt,
      input  in_rd, in_writes_rd, in_fu,
      input  pnd_sgn, out_ready,
      output in_ready, out_valid, out_rs, out_rt,
      output out_rd, out_fu, out_writes_rd,
      output sb_reg_addr, sb_func_uni, sb_wre, stall_cnt
   );

endinterface

// File: rtl/scoreboard_issue_fu_busy_tracker.sv
// Per-functional-unit occupancy counters for structural hazards.
// The ALU is fully pipelined, so its counter is held at zero.
module fu_busy_tracker
   import scoreboard_issue_pkg::*;
#(
   parameter int BUSY_FU1 = 2,
   parameter int BUSY_FU2 = 8,
   parameter int BUSY_FU3 = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        i_fire,
   input  logic [FU_W-1:0]             i_fu,
   output logic [3:0][BUSY_W-1:0]      o_busy
);

   logic [3:0][BUSY_W-1:0] r_busy;
   logic [3:0][BUSY_W-1:0] w_load;

   assign w_load[0] = '0;
   assign w_load[1] = busy_load(BUSY_FU1);
   assign w_load[2] = busy_load(BUSY_FU2);
   assign w_load[3] = busy_load(BUSY_FU3);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_busy <= '0;
      end else begin
         r_busy[FU_ALU] <= '0;
         for (int i = 1; i < 4; i++) begin
            if (i_fire && i_fu == FU_W'(i))
               r_busy[i] <= w_load[i];
            else if (r_busy[i] != '0)
               r_busy[i] <= r_busy[i] - 1'b1;
         end
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/scoreboard_issue.sv
// Issue stage: holds one instruction, blocks on RAW/WAW/structural
// hazards, and marks the destination pending in the scoreboard on issue.
module scoreboard_issue
   import scoreboard_issue_pkg::*;
#(
   parameter int BUSY_FU1 = 2,
   parameter int BUSY_FU2 = 8,
   parameter int BUSY_FU3 = 1,
   parameter int CNT_W    = 16
) (
   input logic               clock,
   input logic               reset,
   scoreboard_issue_if.slave bus
);

   state_e                 r_state;
   state_e                 w_state_nxt;
   instr_t                 r_instr;
   logic                   r_byp_valid;
   logic [REG_ADDR_W-1:0]  r_byp_rd;
   logic [CNT_W-1:0]       r_stall_cnt;

   logic [3:0][BUSY_W-1:0] w_busy;
   logic                   w_pend_rs;
   logic                   w_pend_rt;
   logic                   w_pend_rd;
   logic                   w_raw;
   logic                   w_waw;
   logic                   w_struct;
   logic                   w_held;
   logic                   w_out_valid;
   logic                   w_in_ready;
   logic                   w_fire;
   logic                   w_load;
   logic                   w_mark;

   // The scoreboard shows a new pending bit one cycle late; the bypass covers it.
   assign w_pend_rs = (r_instr.rs != '0) &&
                      (bus.pnd_sgn[r_instr.rs] ||
                       (r_byp_valid && r_byp_rd == r_instr.rs));
   assign w_pend_rt = (r_instr.rt != '0) &&
                      (bus.pnd_sgn[r_instr.rt] ||
                       (r_byp_valid && r_byp_rd == r_instr.rt));
   assign w_pend_rd = (r_instr.rd != '0) &&
                      (bus.pnd_sgn[r_instr.rd] ||
                       (r_byp_valid && r_byp_rd == r_instr.rd));

   assign w_raw    = w_pend_rs || (r_instr.uses_rt && w_pend_rt);
   assign w_waw    = r_instr.writes_rd && w_pend_rd;
   assign w_struct = (w_busy[r_instr.fu] != '0);
   assign w_held   = (r_state == ST_HELD);
   assign w_fire   = w_out_valid && bus.out_ready;
   assign w_load   = bus.in_valid && w_in_ready;
   assign w_mark   = w_fire && r_instr.writes_rd && (r_instr.rd != '0);

   fu_busy_tracker #(
      .BUSY_FU1 (BUSY_FU1),
      .BUSY_FU2 (BUSY_FU2),
      .BUSY_FU3 (BUSY_FU3)
   ) u_busy (
      .clock  (clock),
      .reset  (reset),
      .i_fire (w_fire),
      .i_fu   (r_instr.fu),
      .o_busy (w_busy)
   );

   always_ff @(posedge clock) begin
      if (!reset) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: if (bus.in_valid) w_state_nxt = ST_HELD;
         ST_HELD:  if (w_fire && !bus.in_valid) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   // Outputs are gated by reset so a held instruction never issues while dropped.
   always_comb begin
      w_out_valid = 1'b0;
      w_in_ready  = 1'b0;
      unique case (r_state)
         ST_EMPTY: w_in_ready = 1'b1;
         ST_HELD: begin
            w_out_valid = reset && !w_raw && !w_waw && !w_struct;
            w_in_ready  = w_out_valid && bus.out_ready;
         end
         default: w_in_ready = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_instr <= '0;
      end else if (w_load) begin
         r_instr.rs        <= bus.in_rs;
         r_instr.rt        <= bus.in_rt;
         r_instr.uses_rt   <= bus.in_uses_rt;
         r_instr.rd        <= bus.in_rd;
         r_instr.writes_rd <= bus.in_writes_rd;
         r_instr.fu        <= bus.in_fu;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_byp_valid <= 1'b0;
         r_byp_rd    <= '0;
      end else begin
         r_byp_valid <= w_mark;
         if (w_mark) r_byp_rd <= r_instr.rd;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (w_held && !w_out_valid && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = w_out_valid;
   assign bus.out_rs        = r_instr.rs;
   assign bus.out_rt        = r_instr.rt;
   assign bus.out_rd        = r_instr.rd;
   assign bus.out_fu        = r_instr.fu;
   assign bus.out_writes_rd = r_instr.writes_rd;
   assign bus.sb_reg_addr   = r_instr.rd;
   assign bus.sb_func_uni   = r_instr.fu;
   assign bus.sb_wre        = !w_mark;
   assign bus.stall_cnt     = r_stall_cnt;

endmodule

// File: doc/scoreboard_issue.md
Name: scoreboard_issue

Overview:
- Issue-stage hazard checker, and the write-side client of the register scoreboard.
- Holds one decoded instruction and reads the scoreboard pending vector (pnd_sgn), a per-functional-unit busy state and a one-cycle bypass.
- Releases the instruction to execute only when no RAW, WAW or structural hazard exists.
- On release, drives the scoreboard write port (reg_addr, func_uni, active-low wre) to mark the destination register pending.

Parameters:
- BUSY_FU1, 2, cycles FU1 (MUL) stays occupied after an issue.
- BUSY_FU2, 8, cycles FU2 (DIV) stays occupied after an issue.
- BUSY_FU3, 1, cycles FU3 (LSU) stays occupied after an issue. FU0 (ALU) is fully pipelined and never busy.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  holding register can accept this cycle.
- in_rs  in  5  source register A.
- in_rt  in  5  source register B.
- in_uses_rt  in  1  in_rt is a real operand.
- in_rd  in  5  destination register.
- in_writes_rd  in  1  instruction writes in_rd.
- in_fu  in  2  target functional unit, 0..3.
- pnd_sgn  in  32  pending vector read from the scoreboard.
- out_valid  out  1  held instruction is hazard-free and offered to execute.
- out_ready  in  1  execute accepts.
- out_rs, out_rt, out_rd  out  5 each  held fields.
- out_fu  out  2  held FU.
- out_writes_rd  out  1  held write flag.
- sb_reg_addr  out  5  scoreboard write address; equals held rd.
- sb_func_uni  out  2  scoreboard FU tag; equals held fu.
- sb_wre  out  1  scoreboard write enable, active-low; one-cycle low pulse per issuing writer.
- stall_cnt  out  CNT_W  saturating count of hazard-stalled cycles.

Behaviour:
- Reset (reset==0 at a clock edge): clear held-valid, all FU busy counters, bypass valid and stall_cnt. After reset: out_valid=0, sb_wre=1, in_ready=1, stall_cnt=0, all out_* fields=0.
- State machine, two states:
  - EMPTY: nothing held; in_ready=1. in_valid loads the holding register and moves to HELD.
  - HELD: instruction held.
    - fire = out_valid & out_ready.
    - fire & in_valid: reload the holding register and stay HELD (back-to-back).
    - fire & !in_valid: go to EMPTY.
    - !fire: hold the instruction; in_ready=0.
- in_ready = EMPTY | fire.
- Hazard definitions (combinational on held fields):
  - pend(r) = (r!=0) & (pnd_sgn[r] | (byp_valid & byp_rd==r)).
  - raw = pend(rs) | (uses_rt & pend(rt)).
  - waw = writes_rd & pend(rd).
  - struct = busy[fu]!=0.
  - out_valid = HELD & !raw & !waw & !struct.
- Bypass: the scoreboard sets pending one cycle after its write.
  - On fire with writes_rd & rd!=0, set byp_valid=1 and byp_rd=rd for exactly the next cycle.
  - This covers the cycle in which pnd_sgn does not yet show the new pending bit.
- Scoreboard write: sb_wre = !(fire & writes_rd & rd!=0). sb_reg_addr and sb_func_uni are driven from the held fields every cycle.
- rd==0 never marks a register pending. Register 0 is never a hazard source.
- FU busy counters:
  - Four counters, 4 bits each.
  - On fire, load busy[fu] with BUSY_FUx-1; a value of 0 means the unit is free next cycle.
  - Otherwise decrement toward 0.
  - busy[0] is tied to 0.
  - Example: with BUSY_FU2=8, the next DIV can issue 8 cycles after the previous one.
- Latency: an instruction accepted at edge N can fire, at the earliest, in cycle N+1 (one holding-register stage).
- stall_cnt: increments on every cycle with HELD & !out_valid; saturates at all-ones. Cycles stalled only by !out_ready are not counted.
- Reset taken while HELD: the instruction is dropped and no sb_wre pulse is produced.
- Simultaneous fire and new pend: the bypass applies to the newly loaded instruction in the next cycle.

Decomposition:
- Shared package holds:
  - FU encodings: FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_LSU=3.
  - REG_ADDR_W=5, NUM_REGS=32.
  - State encodings: ST_EMPTY, ST_HELD.
- Sub-module fu_busy_tracker owns the four busy counters.
  - Inputs: fire, fu.
  - Output: busy vector.
- The hazard compare and handshake stay in the top module.

Test Plan:
- Reset, then add r3=r1+r2 (fu=0, pnd_sgn=0, out_ready=1) -> out_valid=1 in cycle 1; sb_wre low for one cycle with sb_reg_addr=3, sb_func_uni=0.
- Back-to-back add r3 then add r4=r3+r0, pnd_sgn held at 0 -> second instruction stalls in its first cycle via the bypass; stall_cnt=1.
- Held instruction with rs=5, pnd_sgn[5]=1 for 4 cycles, then 0 -> out_valid=0 for 4 cycles and 1 on the fifth; stall_cnt=4; in_ready=0 throughout the stall.
- Two DIV instructions with BUSY_FU2=8 and no register dependencies -> second fires exactly 8 cycles after the first; a single ALU instruction between them is not blocked.
- Writer with rd=0 -> fires; sb_wre stays 1; a following reader of r0 does not stall.
- Instruction held and stalled, then reset=0 for one cycle -> out_valid=0, sb_wre=1, in_ready=1, stall_cnt=0 in the next cycle; no scoreboard write occurs.
